mult_div_sequencer: RTL and testbench

- Iterative signed multiply/divide unit with its own sequencing FSM. The main control FSM drives it through a start/done handshake for MULT and DIV.
- Results go to HI/LO. The main FSM stalls in its execute state until done, so it no longer needs its own 31-cycle counter.
- Radix-2: one partial-product or quotient bit per cycle.

---
 rtl/mult_div_sequencer.sv | 165 ++++++++++++++++
 tb/tb_mult_div_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_sequencer.sv
// Iterative radix-2 signed multiply/divide unit with its own start/done sequencer; results land in hi/lo.
// Optional MULT_DIV_UNSIGNED_EN adds op_unsigned for MULTU/DIVU behaviour.
module mult_div_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
`ifdef MULT_DIV_UNSIGNED_EN
  input  logic             op_unsigned,
`endif
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               neg_a, neg_b, dz_q;
  logic [WIDTH-1:0]   m_q;       // multiplicand (MULT) or divisor (DIV) magnitude
  logic [WIDTH:0]     rem;       // upper accumulator / partial remainder
  logic [WIDTH-1:0]   quo;       // multiplier shifting out / quotient shifting in

  logic               sign_en;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     div_shift, div_diff, mul_sum;
  logic [WIDTH-1:0]   rem_lo, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod, prod_fix;

`ifdef MULT_DIV_UNSIGNED_EN
  logic uns_q;
  assign sign_en = ~uns_q;
`else
  assign sign_en = 1'b1;
`endif

  // Sign extraction and magnitude conversion of the latched operands
  assign a_neg = sign_en & a_q[WIDTH-1];
  assign b_neg = sign_en & b_q[WIDTH-1];
  assign mag_a = a_neg ? -a_q : a_q;
  assign mag_b = b_neg ? -b_q : b_q;

  // One iteration step: restoring subtract for DIV, add-then-shift for MULT
  assign div_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, m_q};
  assign mul_sum   = rem + {1'b0, m_q};

  // Sign fix-up; quotient truncates toward zero, remainder follows the dividend
  assign rem_lo   = rem[WIDTH-1:0];
  assign prod     = {rem_lo, quo};
  assign prod_fix = (neg_a ^ neg_b) ? -prod : prod;
  assign quo_fix  = (neg_a ^ neg_b) ? -quo : quo;
  assign rem_fix  = neg_a ? -rem_lo : rem_lo;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      dz_q     <= 1'b0;
      m_q      <= '0;
      rem      <= '0;
      quo      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
`ifdef MULT_DIV_UNSIGNED_EN
      uns_q    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= op;
            a_q   <= operand_a;
            b_q   <= operand_b;
`ifdef MULT_DIV_UNSIGNED_EN
            uns_q <= op_unsigned;
`endif
            busy  <= 1'b1;
            state <= S_PREP;
          end
        end
        S_PREP: begin
          neg_a <= a_neg;
          neg_b <= b_neg;
          rem   <= '0;
          cnt   <= CNT_W'(WIDTH - 1);
          m_q   <= op_q ? mag_b : mag_a;
          quo   <= op_q ? mag_a : mag_b;
          // Divide-by-zero skips the iterations but still spends one cycle in FIX
          if (op_q && (b_q == '0)) begin
            dz_q  <= 1'b1;
            state <= S_FIX;
          end else begin
            dz_q  <= 1'b0;
            state <= S_ITER;
          end
        end
        S_ITER: begin
          if (op_q) begin
            if (div_diff[WIDTH]) begin
              rem <= div_shift;
              quo <= {quo[WIDTH-2:0], 1'b0};
            end else begin
              rem <= div_diff;
              quo <= {quo[WIDTH-2:0], 1'b1};
            end
          end else if (quo[0]) begin
            rem <= {1'b0, mul_sum[WIDTH:1]};
            quo <= {mul_sum[0], quo[WIDTH-1:1]};
          end else begin
            rem <= {1'b0, rem[WIDTH:1]};
            quo <= {rem[0], quo[WIDTH-1:1]};
          end
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - CNT_W'(1);
        end
        S_FIX: begin
          if (dz_q) begin
            div_zero <= 1'b1;
          end else begin
            div_zero <= 1'b0;
            if (op_q) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Scoreboard bench for mult_div_sequencer: expected hi/lo/div_zero queued at issue, compared on each done.
module tb_mult_div_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] operand_a, operand_b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;
`ifdef MULT_DIV_UNSIGNED_EN
  logic        op_unsigned;
`endif

  mult_div_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op        (op),
`ifdef MULT_DIV_UNSIGNED_EN
    .op_unsigned(op_unsigned),
`endif
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .div_zero  (div_zero)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          vectors = 0;
  int          miscompares = 0;
  int          done_count = 0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;

  // Reference model in plain 64-bit arithmetic; div-by-zero keeps the previous result
  function automatic exp_t model(input logic o, input logic u, input logic [31:0] x, input logic [31:0] y);
    exp_t        r;
    longint      p, qq, rr;
    logic [63:0] pu;
    r.dz = 1'b0;
    if (!o) begin
      p  = longint'($signed(x)) * longint'($signed(y));
      pu = {32'b0, x} * {32'b0, y};
      r.hi = u ? pu[63:32] : p[63:32];
      r.lo = u ? pu[31:0]  : p[31:0];
    end else if (y == 32'b0) begin
      r.hi = prev_hi;
      r.lo = prev_lo;
      r.dz = 1'b1;
    end else if (u) begin
      r.lo = x / y;
      r.hi = x % y;
    end else begin
      qq = longint'($signed(x)) / longint'($signed(y));
      rr = longint'($signed(x)) % longint'($signed(y));
      r.lo = qq[31:0];
      r.hi = rr[31:0];
    end
    return r;
  endfunction

  // Scoreboard checker: every done pops one expected entry
  always @(negedge clock) begin
    if (reset === 1'b1 && done === 1'b1) begin
      done_count++;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done hi=%h lo=%h dz=%b", hi, lo, div_zero);
      end else begin
        mon_e = sb.pop_front();
        if ({hi, lo, div_zero} !== {mon_e.hi, mon_e.lo, mon_e.dz}) begin
          miscompares++;
          $display("FAIL result got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=%b",
                   hi, lo, div_zero, mon_e.hi, mon_e.lo, mon_e.dz);
        end
      end
    end
  end

  // Issue one operation, check latency, busy and the single-cycle done pulse
  task automatic issue(input logic o, input logic u, input logic [31:0] x, input logic [31:0] y, input int exp_lat);
    exp_t e;
    int   cyc;
    bit   busy_ok, seen;
    e = model(o, u, x, y);
    sb.push_back(e);
    if (!e.dz) begin
      prev_hi = e.hi;
      prev_lo = e.lo;
    end
    op = o; operand_a = x; operand_b = y; start = 1'b1;
`ifdef MULT_DIV_UNSIGNED_EN
    op_unsigned = u;
`endif
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 0; busy_ok = 1'b1; seen = 1'b0;
    while (cyc < 200 && !seen) begin
      @(posedge clock); #1;
      cyc++;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen || cyc != exp_lat) begin
      miscompares++;
      $display("FAIL latency op=%b a=%h b=%h got %0d cycles (seen=%b) expected %0d", o, x, y, cyc, seen, exp_lat);
    end
    vectors++;
    if (!busy_ok) begin
      miscompares++;
      $display("FAIL busy_high op=%b a=%h b=%h busy dropped before done", o, x, y);
    end
    @(posedge clock); #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse after done got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; op = 1'b0; operand_a = '0; operand_b = '0;
`ifdef MULT_DIV_UNSIGNED_EN
    op_unsigned = 1'b0;
`endif
    #1;
    vectors++;
    if ({busy, done, div_zero, hi, lo} !== 67'b0) begin
      miscompares++;
      $display("FAIL reset_state got busy=%b done=%b dz=%b hi=%h lo=%h expected all 0", busy, done, div_zero, hi, lo);
    end
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
  endtask

  task automatic test_mult;
    issue(1'b0, 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 34);
    vectors++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      miscompares++;
      $display("FAIL mult_7x-3 got %h_%h expected ffffffff_ffffffeb", hi, lo);
    end
  endtask

  task automatic test_div;
    issue(1'b1, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 34);
    vectors++;
    if ({hi, lo, div_zero} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0}) begin
      miscompares++;
      $display("FAIL div_-7/2 got hi=%h lo=%h dz=%b expected ffffffff fffffffd 0", hi, lo, div_zero);
    end
    issue(1'b1, 1'b0, 32'd100, 32'd7, 34);
    vectors++;
    if ({hi, lo} !== {32'd2, 32'd14}) begin
      miscompares++;
      $display("FAIL div_100/7 got hi=%h lo=%h expected 2 14", hi, lo);
    end
  endtask

  task automatic test_div_zero;
    issue(1'b1, 1'b0, 32'd5, 32'd0, 2);
    vectors++;
    if ({hi, lo, div_zero} !== {32'd2, 32'd14, 1'b1}) begin
      miscompares++;
      $display("FAIL div_by_zero got hi=%h lo=%h dz=%b expected 2 e 1", hi, lo, div_zero);
    end
    issue(1'b0, 1'b0, 32'd2, 32'd3, 34);
    vectors++;
    if ({hi, lo, div_zero} !== {32'd0, 32'd6, 1'b0}) begin
      miscompares++;
      $display("FAIL mult_after_dz got hi=%h lo=%h dz=%b expected 0 6 0", hi, lo, div_zero);
    end
  endtask

  task automatic test_boundary;
    issue(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 34);
    vectors++;
    if ({hi, lo} !== 64'h4000_0000_0000_0000) begin
      miscompares++;
      $display("FAIL mult_min_sq got %h_%h expected 40000000_00000000", hi, lo);
    end
    issue(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 34);
    vectors++;
    if ({hi, lo, div_zero} !== {32'h0, 32'h8000_0000, 1'b0}) begin
      miscompares++;
      $display("FAIL div_overflow got hi=%h lo=%h dz=%b expected 0 80000000 0", hi, lo, div_zero);
    end
  endtask

  task automatic test_start_while_busy;
    int dc0, cyc;
    bit seen;
    dc0 = done_count;
    sb.push_back(model(1'b0, 1'b0, 32'h0001_2345, 32'hFFFF_0003));
    op = 1'b0; operand_a = 32'h0001_2345; operand_b = 32'hFFFF_0003; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 0; seen = 1'b0;
    while (cyc < 200 && !seen) begin
      @(posedge clock); #1;
      cyc++;
      if (done === 1'b1) seen = 1'b1;
      if (cyc == 5 || cyc == 20) begin
        start = 1'b1; op = 1'b1; operand_a = $urandom; operand_b = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    vectors++;
    if (!seen || cyc != 34) begin
      miscompares++;
      $display("FAIL busy_start_latency got %0d cycles expected 34", cyc);
    end
    repeat (4) @(posedge clock);
    #1;
    vectors++;
    if (done_count - dc0 != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_start_dones got %0d dones busy=%b expected 1 0", done_count - dc0, busy);
    end
    {prev_hi, prev_lo} = {hi, lo};
  endtask

  task automatic test_reset_mid_op;
    int dc0;
    dc0 = done_count;
    op = 1'b1; operand_a = 32'd1000; operand_b = 32'd3; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    vectors++;
    if ({busy, done, div_zero, hi, lo} !== 67'b0) begin
      miscompares++;
      $display("FAIL mid_reset got busy=%b done=%b dz=%b hi=%h lo=%h expected all 0", busy, done, div_zero, hi, lo);
    end
    prev_hi = '0; prev_lo = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    vectors++;
    if (done_count != dc0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_no_done got %0d dones busy=%b expected 0 0", done_count - dc0, busy);
    end
    issue(1'b0, 1'b0, 32'd3, 32'd4, 34);
    vectors++;
    if ({hi, lo} !== {32'd0, 32'd12}) begin
      miscompares++;
      $display("FAIL mult_3x4 got hi=%h lo=%h expected 0 c", hi, lo);
    end
  endtask

  // Random operations issued with no idle gap between them
  task automatic test_back_to_back;
    logic        o;
    logic [31:0] x, y;
    for (int i = 0; i < 8; i++) begin
      o = 1'($urandom_range(0, 1));
      x = $urandom;
      y = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
      if (i == 5) y = 32'hFFFF_FFFF;
      issue(o, 1'b0, x, y, (o && y == 32'd0) ? 2 : 34);
    end
  endtask

`ifdef MULT_DIV_UNSIGNED_EN
  task automatic test_unsigned;
    issue(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 34);
    vectors++;
    if ({hi, lo} !== {32'd1, 32'hFFFF_FFFE}) begin
      miscompares++;
      $display("FAIL multu got hi=%h lo=%h expected 1 fffffffe", hi, lo);
    end
    issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 34);
  endtask
`endif

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_boundary();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
`ifdef MULT_DIV_UNSIGNED_EN
    test_unsigned();
`endif
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
